tm1638_frame_sequencer: RTL



---
 rtl/tm1638_pkg.sv | 40 ++++
 rtl/tm1638_frame_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: command bytes, frame sequencer states and the
// BCD-to-seven-segment encoder used by the display blocks.
package tm1638_pkg;

    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON    = 8'h88;
    localparam logic [7:0] CMD_DISP_OFF   = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MODE = 3'd1,
        ST_GAP1 = 3'd2,
        ST_ADDR = 3'd3,
        ST_DATA = 3'd4,
        ST_GAP2 = 3'd5,
        ST_DISP = 3'd6,
        ST_DONE = 3'd7
    } seq_state_t;

    // Active-high segments, bit0=a .. bit6=g, dp off; non-BCD codes show 'E'.
    function automatic logic [7:0] seg(input logic [3:0] bcd);
        logic [7:0] code_s;
        case (bcd)
            4'd0:    code_s = 8'h3F;
            4'd1:    code_s = 8'h06;
            4'd2:    code_s = 8'h5B;
            4'd3:    code_s = 8'h4F;
            4'd4:    code_s = 8'h66;
            4'd5:    code_s = 8'h6D;
            4'd6:    code_s = 8'h7D;
            4'd7:    code_s = 8'h07;
            4'd8:    code_s = 8'h7F;
            4'd9:    code_s = 8'h6F;
            default: code_s = 8'h79;
        endcase
        return code_s;
    endfunction

endpackage

// File: rtl/tm1638_frame_sequencer.sv
// Emits one full TM1638 frame (mode, address + 16 RAM bytes, display control)
// as a byte stream on a valid/ready handshake towards the STB/CLK/DIO shifter.
module tm1638_frame_sequencer
    import tm1638_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned TENS_ADDR   = 0,
    parameter int unsigned DIGITS_ADDR = 2
) (
    input  logic       Clk_50M,
    input  logic       RST,
    input  logic       frame_req,
    input  logic [3:0] tens,
    input  logic [3:0] digits,
    input  logic [2:0] brightness,
    input  logic       disp_on,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_end,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned    GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]     TENS_IDX   = 4'(TENS_ADDR);
    localparam logic [3:0]     DIGITS_IDX = 4'(DIGITS_ADDR);
    localparam logic [3:0]     LAST_IDX   = 4'd15;

    seq_state_t       state_r, state_s;
    logic             pending_r, pending_s;
    logic [3:0]       idx_r, idx_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic [3:0]       tens_r, tens_s;
    logic [3:0]       digits_r, digits_s;
    logic [2:0]       bright_r, bright_s;
    logic             on_r, on_s;
    logic [7:0]       tx_data_s;
    logic             tx_valid_s, tx_end_s, busy_s, frame_done_s;
    logic             xfer_s;

    // Display RAM image; tens is checked first so it wins on an address clash.
    function automatic logic [7:0] ram_byte(input logic [3:0] idx,
                                            input logic [3:0] t,
                                            input logic [3:0] d);
        logic [7:0] byte_s;
        if (idx == TENS_IDX) begin
            byte_s = seg(t);
        end else if (idx == DIGITS_IDX) begin
            byte_s = seg(d);
        end else begin
            byte_s = 8'h00;
        end
        return byte_s;
    endfunction

    assign xfer_s = tx_valid & tx_ready;

    // State, snapshot and output registers; outputs are precomputed from next state.
    always_ff @(posedge Clk_50M) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            pending_r  <= 1'b1;
            idx_r      <= 4'd0;
            gap_r      <= '0;
            tens_r     <= 4'd0;
            digits_r   <= 4'd0;
            bright_r   <= 3'd0;
            on_r       <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            tx_end     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            pending_r  <= pending_s;
            idx_r      <= idx_s;
            gap_r      <= gap_s;
            tens_r     <= tens_s;
            digits_r   <= digits_s;
            bright_r   <= bright_s;
            on_r       <= on_s;
            tx_data    <= tx_data_s;
            tx_valid   <= tx_valid_s;
            tx_end     <= tx_end_s;
            busy       <= busy_s;
            frame_done <= frame_done_s;
        end
    end

    // Next-state logic; a request in any state (even while consuming one) is kept.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r | frame_req;
        idx_s     = idx_r;
        gap_s     = gap_r;
        tens_s    = tens_r;
        digits_s  = digits_r;
        bright_s  = bright_r;
        on_s      = on_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r) begin
                    tens_s    = tens;
                    digits_s  = digits;
                    bright_s  = brightness;
                    on_s      = disp_on;
                    pending_s = frame_req;
                    state_s   = ST_MODE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MODE: begin
                if (xfer_s) begin
                    state_s = ST_GAP1;
                    gap_s   = '0;
                end else begin
                    state_s = ST_MODE;
                end
            end
            ST_GAP1: begin
                if (gap_r == GAP_LAST) begin
                    state_s = ST_ADDR;
                    gap_s   = '0;
                end else begin
                    gap_s = gap_r + 1'b1;
                end
            end
            ST_ADDR: begin
                if (xfer_s) begin
                    state_s = ST_DATA;
                    idx_s   = 4'd0;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (xfer_s && (idx_r == LAST_IDX)) begin
                    state_s = ST_GAP2;
                    idx_s   = 4'd0;
                    gap_s   = '0;
                end else if (xfer_s) begin
                    idx_s = idx_r + 4'd1;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_GAP2: begin
                if (gap_r == GAP_LAST) begin
                    state_s = ST_DISP;
                    gap_s   = '0;
                end else begin
                    gap_s = gap_r + 1'b1;
                end
            end
            ST_DISP: begin
                if (xfer_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DISP;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so a stalled byte stays bit-identical.
    always_comb begin
        tx_data_s    = 8'h00;
        tx_valid_s   = 1'b0;
        tx_end_s     = 1'b0;
        busy_s       = 1'b0;
        frame_done_s = 1'b0;
        case (state_s)
            ST_IDLE: busy_s = 1'b0;
            ST_MODE: begin
                tx_data_s  = CMD_WRITE_AUTO;
                tx_valid_s = 1'b1;
                tx_end_s   = 1'b1;
                busy_s     = 1'b1;
            end
            ST_GAP1: busy_s = 1'b1;
            ST_ADDR: begin
                tx_data_s  = CMD_ADDR0;
                tx_valid_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DATA: begin
                tx_data_s  = ram_byte(idx_s, tens_s, digits_s);
                tx_valid_s = 1'b1;
                tx_end_s   = (idx_s == LAST_IDX);
                busy_s     = 1'b1;
            end
            ST_GAP2: busy_s = 1'b1;
            ST_DISP: begin
                if (on_s) begin
                    tx_data_s = CMD_DISP_ON | {5'b00000, bright_s};
                end else begin
                    tx_data_s = CMD_DISP_OFF;
                end
                tx_valid_s = 1'b1;
                tx_end_s   = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DONE: frame_done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

endmodule
